// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg
// Shared CPU types: data word plus the instruction-cache frame layout
// and the cache FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS = 16;
    localparam int IIDX_W      = $clog2(ICACHE_SETS);
    localparam int ITAG_W      = 32 - IIDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_direct.sv
// ============================================================================
// icache_direct
// Direct-mapped read-only instruction cache. Combinational hit path from a
// frame array; a miss runs a one-word fill over the iREN/iwait handshake and
// the following IDLE cycle re-looks-up the now valid frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_direct
    import cpu_types_pkg::*;
#(
    // Frame tag width comes from the package, so SETS has to stay at ICACHE_SETS.
    parameter int SETS  = ICACHE_SETS,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  word_t            imemaddr,
    output logic             ihit,
    output word_t            imemload,
    output logic             iREN,
    output word_t            iaddr,
    input  logic             iwait,
    input  word_t            iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);

    icache_state_t     state_q, state_d;
    icache_frame_t     frames_q [SETS];
    word_t             miss_addr_q;
    logic [CNT_W-1:0]  hit_count_q, miss_count_q;

    logic [IDX_W-1:0]  req_idx;
    logic [ITAG_W-1:0] req_tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [ITAG_W-1:0] miss_tag;
    icache_frame_t     req_frame;
    logic              req_match;
    logic              miss_start;
    logic              fill;

    assign req_idx   = imemaddr[IDX_W+1:2];
    assign req_tag   = imemaddr[31:IDX_W+2];
    assign miss_idx  = miss_addr_q[IDX_W+1:2];
    assign miss_tag  = miss_addr_q[31:IDX_W+2];
    assign req_frame = frames_q[req_idx];
    assign req_match = req_frame.valid && (req_frame.tag == req_tag);

    // Fill data is never forwarded; imemload always reflects the looked-up frame.
    assign imemload   = req_frame.data;
    assign iaddr      = miss_addr_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // State register; reset drops straight to IDLE so iREN falls asynchronously.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs: lookups in IDLE, memory fill in FETCH.
    always_comb begin
        state_d    = state_q;
        ihit       = 1'b0;
        iREN       = 1'b0;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                ihit = imemREN && req_match;
                if (imemREN && !req_match) begin
                    miss_start = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame array: only valid bits are reset; a fill overwrites the whole frame.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i].valid <= 1'b0;
            end
        end else if (fill) begin
            frames_q[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
        end
    end

    // Miss address is captured word-aligned and held until the next miss.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_addr_q <= '0;
        end else if (miss_start) begin
            miss_addr_q <= {imemaddr[31:2], 2'b00};
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (ihit) begin
                hit_count_q <= hit_count_q + CNT_W'(1);
            end
            if (miss_start) begin
                miss_count_q <= miss_count_q + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
